// File: rtl/image_receiver_pkg.sv
// Types and constants shared by both ends of the UART pixel link.
package image_link_pkg;

  typedef logic [11:0] pixel_t;

  localparam int CLKS_PER_BIT_50M_9600 = 50_000_000 / 9600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } asm_state_t;

  // A high byte carries only four pixel bits; a non-zero upper nibble means we are misaligned.
  function automatic logic hi_byte_ok(input logic [3:0] upper);
    return (upper == 4'h0);
  endfunction

endpackage

// File: rtl/image_receiver_if.sv
// Frame-buffer write port driven by the receiver: address, pixel data and write strobe.
import image_link_pkg::*;

interface image_receiver_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] address;
  pixel_t            pixel;
  logic              wren;

  modport master (output address, output pixel, output wren);
  modport slave  (input  address, input  pixel, input  wren);
endinterface

// File: rtl/image_receiver_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, centre sampling, one-cycle rx_valid / framing_err pulses.
import image_link_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic       sync1_r, sync2_r, prev_r;
  rx_state_t  state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0] bit_r, bit_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] byte_r, byte_s;
  logic       valid_r, valid_s;
  logic       ferr_r, ferr_s;

  // Synchroniser (resets to idle-high) plus one stage of history for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Bit-level state register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      byte_r  <= byte_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
    end
  end

  // Next-state: the stop bit is judged at its centre so the following start edge is never missed.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    byte_s  = byte_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        bit_s = 3'd0;
        if (prev_r && !sync2_r) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_s   = CNT_ZERO;
          state_s = sync2_r ? IDLE : DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = CNT_ZERO;
          shift_s = {sync2_r, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_s   = CNT_ZERO;
          state_s = IDLE;
          if (sync2_r) begin
            valid_s = 1'b1;
            byte_s  = shift_r;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign rx_byte     = byte_r;
  assign rx_valid    = valid_r;
  assign framing_err = ferr_r;

endmodule

// File: rtl/image_receiver.sv
// Image frame receiver: UART bytes -> RGB444 pixels -> sequential frame-buffer writes.
// Optional mid-frame abort on line silence is built when FRAME_TIMEOUT_EN is defined.
import image_link_pkg::*;

module image_receiver #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_9600,
  parameter int NUM_PIXELS   = 76800,
`ifdef FRAME_TIMEOUT_EN
  parameter int ADDR_W       = 17,
  parameter int TIMEOUT_CLKS = 4 * 10 * CLKS_PER_BIT
`else
  parameter int ADDR_W       = 17
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_in,
  image_receiver_if.master   fb,
  output logic               image_ready,
  output logic               sync_err,
  output logic               framing_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic rst_meta_r, rst_sync_r;

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;
  logic       rx_ferr_s;

  asm_state_t        asm_r, asm_s;
  logic [3:0]        hi_r, hi_s;
  logic [ADDR_W-1:0] index_r, index_s;
  logic [ADDR_W-1:0] address_r, address_s;
  pixel_t            pixel_r, pixel_s;
  logic              wren_r, wren_s;
  logic              ready_r, ready_s;
  logic              sync_err_r, sync_err_s;

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] to_r, to_s;
`endif

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk         (clk),
    .rst         (rst_sync_r),
    .rx          (uart_in),
    .rx_byte     (rx_byte_s),
    .rx_valid    (rx_valid_s),
    .framing_err (rx_ferr_s)
  );

  // Assembler state, pixel index and registered frame-buffer outputs.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      asm_r      <= WAIT_HI;
      hi_r       <= 4'h0;
      index_r    <= IDX_ZERO;
      address_r  <= IDX_ZERO;
      pixel_r    <= 12'h000;
      wren_r     <= 1'b0;
      ready_r    <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      asm_r      <= asm_s;
      hi_r       <= hi_s;
      index_r    <= index_s;
      address_r  <= address_s;
      pixel_r    <= pixel_s;
      wren_r     <= wren_s;
      ready_r    <= ready_s;
      sync_err_r <= sync_err_s;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  // Idle-line counter for the mid-frame abort.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      to_r <= TO_ZERO;
    end else begin
      to_r <= to_s;
    end
  end
`endif

  // Byte pairing: high byte latches the nibble, low byte issues the write one clock later.
  always_comb begin
    asm_s      = asm_r;
    hi_s       = hi_r;
    index_s    = index_r;
    address_s  = address_r;
    pixel_s    = pixel_r;
    wren_s     = 1'b0;
    sync_err_s = 1'b0;
    if (wren_r && (address_r == LAST_IDX)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = ready_r;
    end
    case (asm_r)
      WAIT_HI: begin
        if (rx_valid_s) begin
          if (hi_byte_ok(rx_byte_s[7:4])) begin
            hi_s    = rx_byte_s[3:0];
            asm_s   = WAIT_LO;
            ready_s = 1'b0;
          end else begin
            sync_err_s = 1'b1;
          end
        end else begin
          asm_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (rx_valid_s) begin
          wren_s    = 1'b1;
          address_s = index_r;
          pixel_s   = {hi_r, rx_byte_s};
          asm_s     = WAIT_HI;
          if (index_r == LAST_IDX) begin
            index_s = IDX_ZERO;
          end else begin
            index_s = index_r + IDX_ONE;
          end
        end else if (rx_ferr_s) begin
          asm_s = WAIT_HI;
        end else begin
          asm_s = WAIT_LO;
        end
      end
      default: begin
        asm_s = WAIT_HI;
      end
    endcase
`ifdef FRAME_TIMEOUT_EN
    // Silence only counts while a frame is partially received.
    to_s = TO_ZERO;
    if (rx_valid_s) begin
      to_s = TO_ZERO;
    end else if ((index_r != IDX_ZERO) || (asm_r == WAIT_LO)) begin
      if (to_r == TO_LAST) begin
        to_s       = TO_ZERO;
        index_s    = IDX_ZERO;
        asm_s      = WAIT_HI;
        sync_err_s = 1'b1;
      end else begin
        to_s = to_r + TO_ONE;
      end
    end else begin
      to_s = TO_ZERO;
    end
`endif
  end

  assign fb.address  = address_r;
  assign fb.pixel    = pixel_r;
  assign fb.wren     = wren_r;
  assign image_ready = ready_r;
  assign sync_err    = sync_err_r;
  assign framing_err = rx_ferr_s;

endmodule

// File: tb/tb_image_receiver.sv
// Self-checking bench for image_receiver: byte-level pixel model plus directed frame scenarios.
`timescale 1ns/1ps
module tb_image_receiver;
  import image_link_pkg::*;

  localparam int CPB = 8;
  localparam int NP  = 3;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_in = 1'b1;
  logic image_ready, sync_err, framing_err;

  image_receiver_if #(.ADDR_W(AW)) fb();

  image_receiver #(
    .CLKS_PER_BIT (CPB),
    .NUM_PIXELS   (NP),
`ifdef FRAME_TIMEOUT_EN
    .ADDR_W       (AW),
    .TIMEOUT_CLKS (200)
`else
    .ADDR_W       (AW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_in     (uart_in),
    .fb          (fb),
    .image_ready (image_ready),
    .sync_err    (sync_err),
    .framing_err (framing_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: what the wire bytes mean, independent of any receiver timing.
  typedef struct packed { logic [31:0] addr; logic [11:0] pix; } wr_t;
  wr_t  exp_q[$];
  logic m_pending = 1'b0;
  logic [3:0] m_hi = 4'h0;
  int   m_index = 0;
  logic m_ready = 1'b0;
  int   m_sync = 0;
  int   m_frame = 0;

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    wr_t w;
    if (!stop_ok) begin
      m_frame++;
      m_pending = 1'b0;
    end else if (!m_pending) begin
      if (b[7:4] == 4'h0) begin
        m_pending = 1'b1;
        m_hi = b[3:0];
        m_ready = 1'b0;
      end else begin
        m_sync++;
      end
    end else begin
      w.addr = m_index;
      w.pix = {m_hi, b};
      exp_q.push_back(w);
      m_index = (m_index + 1) % NP;
      if (m_index == 0) m_ready = 1'b1;
      m_pending = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_index = 0;
    m_ready = 1'b0;
  endtask

  // Observation side.
  int   obs_sync = 0, obs_frame = 0;
  logic [31:0] last_addr = 32'd0;
  logic [11:0] last_pix = 12'h000;
  logic prev_wren = 1'b0, prev_sync = 1'b0, prev_frame = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      check("reset_outputs", {13'd0, fb.address, fb.pixel, fb.wren, image_ready, sync_err, framing_err}, 32'd0);
      prev_wren = 1'b0;
      prev_sync = 1'b0;
      prev_frame = 1'b0;
    end else begin
      if (prev_wren) check("ready_after_wren", {31'd0, image_ready}, {31'd0, (prev_addr == AW'(NP - 1))});
      if (fb.wren) begin
        check("wren_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
        check("wren_single_cycle", {31'd0, prev_wren}, 32'd0);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wr_address", {28'd0, fb.address}, w.addr);
          check("wr_pixel", {20'd0, fb.pixel}, {20'd0, w.pix});
        end
        last_addr = {28'd0, fb.address};
        last_pix = fb.pixel;
      end
      if (sync_err) begin
        obs_sync++;
        check("sync_err_pulse", {31'd0, prev_sync}, 32'd0);
      end
      if (framing_err) begin
        obs_frame++;
        check("framing_err_pulse", {31'd0, prev_frame}, 32'd0);
      end
      prev_wren = fb.wren;
      prev_addr = fb.address;
      prev_sync = sync_err;
      prev_frame = framing_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(CPB);
    end
    model_byte(b, stop_ok);
    uart_in = stop_ok;
    tick(CPB);
    uart_in = 1'b1;
    tick(CPB);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    tick(4);
    rst = 1'b1;
    tick(6);
  endtask

  task automatic checkpoint(input string name);
    tick(4);
    check({name, "_pending_writes"}, exp_q.size(), 32'd0);
    check({name, "_image_ready"}, {31'd0, image_ready}, {31'd0, m_ready});
    check({name, "_sync_count"}, obs_sync, m_sync);
    check({name, "_framing_count"}, obs_frame, m_frame);
  endtask

  initial begin
    uart_in = 1'b1;
    do_reset();

    // Full 3-pixel frame with wrap.
    send_byte(8'h00, 1'b1); send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0F, 1'b1);
    send_byte(8'h0F, 1'b1); send_byte(8'h00, 1'b1);
    checkpoint("t1");
    check("t1_ready_literal", {31'd0, image_ready}, 32'd1);
    check("t1_last_pixel", {20'd0, last_pix}, 32'h0000_0F00);
    check("t1_last_addr", last_addr, 32'd2);

    // Next frame: ready drops when the high byte is accepted.
    send_byte(8'h0A, 1'b1);
    check("t2_ready_dropped", {31'd0, image_ready}, 32'd0);
    send_byte(8'hBC, 1'b1);
    checkpoint("t2");
    check("t2_last_pixel", {20'd0, last_pix}, 32'h0000_0ABC);
    check("t2_last_addr", last_addr, 32'd0);

    // Misaligned high byte rejected.
    do_reset();
    send_byte(8'hF0, 1'b1);
    check("t3_sync_literal", obs_sync, 32'd1);
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    checkpoint("t3");
    check("t3_last_pixel", {20'd0, last_pix}, 32'h0000_0123);

    // Bad stop bit in WAIT_HI, then in WAIT_LO (pending nibble dropped).
    do_reset();
    send_byte(8'h55, 1'b0);
    check("t4_framing_literal", obs_frame, 32'd1);
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h77, 1'b0);
    send_byte(8'h02, 1'b1); send_byte(8'h34, 1'b1);
    checkpoint("t4");
    check("t4_last_pixel", {20'd0, last_pix}, 32'h0000_0234);
    check("t4_last_addr", last_addr, 32'd1);

    // Reset in the middle of a data bit of the low byte.
    do_reset();
    send_byte(8'h04, 1'b1);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_in = 1'(8'h56 >> i);
      tick(CPB);
    end
    tick(CPB / 2);
    rst = 1'b0;
    model_reset();
    tick(4);
    uart_in = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(6);
    send_byte(8'h04, 1'b1); send_byte(8'h56, 1'b1);
    checkpoint("t5");
    check("t5_last_pixel", {20'd0, last_pix}, 32'h0000_0456);
    check("t5_last_addr", last_addr, 32'd0);

    // Stalled partial frame.
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h23, 1'b1);
    tick(230);
`ifdef FRAME_TIMEOUT_EN
    m_index = 0;
    m_pending = 1'b0;
    m_sync++;
`endif
    checkpoint("t6_idle");
    send_byte(8'h07, 1'b1); send_byte(8'h89, 1'b1);
    checkpoint("t6");
    check("t6_last_pixel", {20'd0, last_pix}, 32'h0000_0789);
`ifdef FRAME_TIMEOUT_EN
    check("t6_last_addr", last_addr, 32'd0);
`else
    check("t6_last_addr", last_addr, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
